// File: rtl/glb_bus_scheduler.sv
// Transfer scheduler: stages tagged upstream words in a FIFO and broadcasts them to the
// multicaster bus, counting a configured number of words per transfer.
module glb_bus_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cfg_start,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [ID_WIDTH-1:0]           in_row_id,
  input  logic [ID_WIDTH-1:0]           in_col_id,
  output logic                          bus_valid,
  input  logic                          bus_ready,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic [ID_WIDTH-1:0]           bus_row_id,
  output logic [ID_WIDTH-1:0]           bus_col_id,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 2 * ID_WIDTH;

  // Column IDs are passed through untouched; NUM_COL only has to be a sane value.
  if (NUM_COL == 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("glb_bus_scheduler: illegal NUM_COL or FIFO_DEPTH");
  end

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] accepted_q;
  logic [LEN_WIDTH-1:0] sent_q;
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        rptr_q;
  logic [CW-1:0]        count_q;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [EW-1:0] head;

  // in_ready depends only on registered state, never on bus_ready.
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign in_ready  = (state_q == StStream) && !fifo_full && (accepted_q < len_q);
  assign push      = in_valid && in_ready;
  assign bus_valid = (count_q != '0);
  assign pop       = bus_valid && bus_ready;
  assign last_pop  = pop && (state_q == StStream) && ((sent_q + LEN_WIDTH'(1)) == len_q);

  // Payload reads as zero whenever nothing is staged, so a flushed FIFO shows a clean bus.
  assign head = mem_q[rptr_q];
  assign {bus_data, bus_row_id, bus_col_id} = bus_valid ? head : '0;

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign fifo_count = count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      accepted_q <= '0;
      sent_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_start) begin
            len_q      <= cfg_len;
            accepted_q <= '0;
            sent_q     <= '0;
            state_q    <= (cfg_len != '0) ? StStream : StDone;
          end
        end
        StStream: begin
          if (push) accepted_q <= accepted_q + LEN_WIDTH'(1);
          if (pop) sent_q <= sent_q + LEN_WIDTH'(1);
          if (last_pop) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_data, in_row_id, in_col_id};
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));
  a_count_bound: assert property (@(posedge clk) disable iff (!rstn) count_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_glb_bus_scheduler.sv
// Randomized and directed bench for glb_bus_scheduler against a queue-based transfer model.
module tb_glb_bus_scheduler;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int DEPTH = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_start;
  logic [LW-1:0] cfg_len;
  logic          busy, done;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_row_id, in_col_id;
  logic          bus_valid, bus_ready;
  logic [DW-1:0] bus_data;
  logic [IW-1:0] bus_row_id, bus_col_id;
  logic [$clog2(DEPTH):0] fifo_count;

  glb_bus_scheduler #(
    .DATA_WIDTH(DW), .NUM_COL(4), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_len(cfg_len), .busy(busy),
    .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_row_id(in_row_id), .in_col_id(in_col_id), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_data(bus_data), .bus_row_id(bus_row_id),
    .bus_col_id(bus_col_id), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: phase 0 idle, 1 streaming, 2 done; FIFO contents as a queue.
  int          ms = 0;
  int          mlen = 0, macc = 0, msent = 0;
  logic [23:0] mq[$];
  bit          seen_start = 0;

  int n_done, n_busy, n_pop, n_bv, max_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_stats();
    n_done = 0; n_busy = 0; n_pop = 0; n_bv = 0; max_cnt = 0;
  endtask

  task automatic rand_data();
    in_data   = DW'($urandom);
    in_row_id = IW'($urandom);
    in_col_id = IW'($urandom);
  endtask

  // One clock: inputs were set at the preceding negedge; check, then advance the model.
  task automatic tick();
    bit          exp_ir, exp_bv, push, pop;
    logic [23:0] head;
    #1;
    if (!rstn) begin
      mq.delete(); ms = 0; mlen = 0; macc = 0; msent = 0; seen_start = 0;
    end
    exp_ir = (ms == 1) && (mq.size() < DEPTH) && (macc < mlen);
    exp_bv = (mq.size() != 0);
    chk("in_ready", in_ready, exp_ir);
    chk("bus_valid", bus_valid, exp_bv);
    chk("busy", busy, ms != 0);
    chk("done", done, ms == 2);
    chk("fifo_count", fifo_count, mq.size());
    if (exp_bv) begin
      head = mq[0];
      chk("bus_payload", {bus_data, bus_row_id, bus_col_id}, head);
    end else if (!seen_start) begin
      chk("bus_payload_zero", {bus_data, bus_row_id, bus_col_id}, 24'h0);
    end
    if (done) n_done++;
    if (busy) n_busy++;
    if (bus_valid) n_bv++;
    if (bus_valid && bus_ready) n_pop++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (rstn) begin
      push = in_valid && exp_ir;
      pop  = exp_bv && bus_ready;
      case (ms)
        0: if (cfg_start) begin
          seen_start = 1;
          mlen = int'(cfg_len); macc = 0; msent = 0;
          ms = (mlen != 0) ? 1 : 2;
        end
        1: begin
          if (pop) begin
            void'(mq.pop_front());
            msent++;
          end
          if (push) begin
            mq.push_back({in_data, in_row_id, in_col_id});
            macc++;
          end
          if (pop && msent == mlen) ms = 2;
        end
        default: ms = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic start(input int len);
    cfg_start = 1'b1;
    cfg_len   = LW'(len);
    tick();
    cfg_start = 1'b0;
  endtask

  // Runs until the model is idle; mode 1 randomizes handshakes and stray cfg_start.
  task automatic drain(input int max_cycles, input bit rnd);
    int i;
    for (i = 0; i < max_cycles && ms != 0; i++) begin
      rand_data();
      if (rnd) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        bus_ready = ($urandom_range(0, 2) != 0);
        cfg_start = ($urandom_range(0, 7) == 0);
        cfg_len   = LW'($urandom_range(0, 30));
      end
      tick();
    end
    cfg_start = 1'b0;
    if (ms != 0) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_len = '0; in_valid = 1'b0; bus_ready = 1'b0;
    in_data = '0; in_row_id = '0; in_col_id = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    rstn = 1'b1;
    in_valid = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Single word
    clr_stats();
    in_valid = 1'b0;
    start(1);
    in_valid = 1'b1; in_data = 16'h1234; in_row_id = 4'd2; in_col_id = 4'd3;
    chk("single_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("single_bus", {bus_valid, bus_data, bus_row_id, bus_col_id}, {1'b1, 24'h123423});
    drain(10, 0);
    chk("single_done_cnt", n_done, 1);
    chk("single_busy_after", busy, 0);

    // Backpressure
    clr_stats();
    start(12);
    in_valid = 1'b1; bus_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      tick();
    end
    chk("bp_count", fifo_count, 8);
    chk("bp_ready", in_ready, 0);
    bus_ready = 1'b1;
    drain(40, 0);
    chk("bp_pops", n_pop, 12);
    chk("bp_done_cnt", n_done, 1);

    // Zero length
    tick();
    clr_stats();
    in_valid = 1'b0;
    start(0);
    drain(5, 0);
    tick();
    chk("zero_busy_cycles", n_busy, 1);
    chk("zero_done_cnt", n_done, 1);
    chk("zero_bus_valid", n_bv, 0);

    // Full-rate streaming
    clr_stats();
    start(20);
    in_valid = 1'b1; bus_ready = 1'b1;
    drain(60, 0);
    chk("rate_pops", n_pop, 20);
    chk("rate_max_count", max_cnt, 1);
    chk("rate_busy_cycles", n_busy, 22);

    // Mid-transfer reset
    start(10);
    bus_ready = 1'b0;
    begin
      int i;
      for (i = 0; i < 20 && fifo_count != 5; i++) begin
        rand_data();
        tick();
      end
      chk("mrst_reach5", fifo_count, 5);
    end
    rstn = 1'b0;
    #1;
    chk("mrst_async_bv", bus_valid, 0);
    chk("mrst_async_cnt", fifo_count, 0);
    tick();
    rstn = 1'b1;
    tick();
    clr_stats();
    in_valid = 1'b1; bus_ready = 1'b1;
    start(3);
    drain(20, 0);
    chk("mrst_pops", n_pop, 3);
    chk("mrst_done_cnt", n_done, 1);

    // Start while busy
    clr_stats();
    start(4);
    tick();
    tick();
    cfg_start = 1'b1; cfg_len = 16'd9;
    tick();
    cfg_start = 1'b0;
    drain(30, 0);
    chk("busy_start_pops", n_pop, 4);
    chk("busy_start_done", n_done, 1);

    // Random transfers
    for (int t = 0; t < 40; t++) begin
      clr_stats();
      in_valid  = ($urandom_range(0, 1) != 0);
      bus_ready = ($urandom_range(0, 1) != 0);
      start($urandom_range(0, 20));
      drain(400, 1);
      chk("rand_done_cnt", n_done, 1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
